// File: rtl/sobel_pkg.sv
// sobel_pkg: constants and types shared by the Sobel front end.
//   PIXEL_W     default pixel width
//   DIR_*       scan direction codes produced by move_control
//   ld_state_t  window_loader FSM states
package sobel_pkg;

  localparam int PIXEL_W = 8;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/window_shift_reg.sv
// window_shift_reg: 3x3 pixel register array.
//   clk, n_reset     clock, async active-low reset (clears all pixels)
//   i_shift_en       shift the whole window one step along i_dir
//   i_dir            DIR_RIGHT: col c <= col c+1, DIR_LEFT: col c <= col c-1,
//                    DIR_DOWN: row r <= row r+1, DIR_NONE: hold
//   i_wr_en          write i_wr_data into slot (i_wr_row, i_wr_col)
//   o_window         pixel (r,c) at bits [PIXEL_W*(3r+c) +: PIXEL_W]
module window_shift_reg
  import sobel_pkg::*;
#(
  parameter int PIXEL_W = sobel_pkg::PIXEL_W
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 i_shift_en,
  input  logic [1:0]           i_dir,
  input  logic                 i_wr_en,
  input  logic [1:0]           i_wr_row,
  input  logic [1:0]           i_wr_col,
  input  logic [PIXEL_W-1:0]   i_wr_data,
  output logic [9*PIXEL_W-1:0] o_window
);

  // [row][col][bit]; packing order matches the flat window layout
  logic [2:0][2:0][PIXEL_W-1:0] r_pix;

  // Shift and write are never requested together by the loader; shift wins.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_pix <= '0;
    end else if (i_shift_en) begin
      case (i_dir)
        DIR_RIGHT: begin
          r_pix[0][1:0] <= r_pix[0][2:1];
          r_pix[1][1:0] <= r_pix[1][2:1];
          r_pix[2][1:0] <= r_pix[2][2:1];
        end
        DIR_LEFT: begin
          r_pix[0][2:1] <= r_pix[0][1:0];
          r_pix[1][2:1] <= r_pix[1][1:0];
          r_pix[2][2:1] <= r_pix[2][1:0];
        end
        DIR_DOWN: r_pix[1:0] <= r_pix[2:1];
        default: ;
      endcase
    end else if (i_wr_en) begin
      r_pix[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  assign o_window = r_pix;

endmodule

// File: rtl/window_loader.sv
// window_loader: fetches and maintains the 3x3 window for the Sobel stage.
// Full load reads 9 pixels; a move shifts the window and reads the 3 new ones.
// One single-pixel read outstanding at a time.
//   clk, n_reset          clock, async active-low reset
//   width                 image row pitch (pixels)
//   base_addr             window top-left address
//   direction             01 right, 10 left, 11 row advance, 00 none
//   load_initial          request full load (wins over start_fetch)
//   start_fetch           request incremental fetch (full load if direction 00)
//   mem_ren/mem_addr      read strobe / address to image memory
//   mem_rdata/mem_rvalid  read return
//   window, window_valid  3x3 window and one-cycle completion strobe
//   busy                  FSM not idle
//   mem_err               sticky read timeout (only with WINDOW_LOADER_TIMEOUT_EN)
// Build option: define WINDOW_LOADER_TIMEOUT_EN to abort a read after 16
// cycles without mem_rvalid; otherwise WAIT waits forever and mem_err is 0.
module window_loader
  import sobel_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int PIXEL_W = sobel_pkg::PIXEL_W
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [11:0]          width,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [1:0]           direction,
  input  logic                 load_initial,
  input  logic                 start_fetch,
  output logic                 mem_ren,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIXEL_W-1:0]   mem_rdata,
  input  logic                 mem_rvalid,
  output logic [9*PIXEL_W-1:0] window,
  output logic                 window_valid,
  output logic                 busy,
  output logic                 mem_err
);

  ld_state_t         r_state;
  logic [ADDR_W-1:0] r_base;
  logic [11:0]       r_width;
  logic [1:0]        r_dir;
  logic              r_full;
  logic [1:0]        r_row, r_col;   // slot of the read in flight
  logic [3:0]        r_cnt;          // pixels already captured
  logic              r_mem_ren;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_valid;

  logic       w_accept, w_full_req, w_shift_en, w_wr_en, w_last;
  logic [1:0] w_row0, w_col0, w_next_row, w_next_col;

  // base + r*width + c, wrapping modulo 2^ADDR_W
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [11:0] w,
                                                 input logic [1:0] row,
                                                 input logic [1:0] col);
    logic [ADDR_W-1:0] w_a;
    logic [ADDR_W-1:0] off;
    w_a = ADDR_W'(w);
    off = (row == 2'd2) ? (w_a << 1) : (row == 2'd1) ? w_a : '0;
    pix_addr = base + off + ADDR_W'(col);
  endfunction

  assign w_accept   = (r_state == ST_IDLE) && (load_initial || start_fetch);
  assign w_full_req = load_initial || (direction == DIR_NONE);
  assign w_shift_en = w_accept && !w_full_req;
  assign w_wr_en    = (r_state == ST_WAIT) && mem_rvalid;
  assign w_last     = (r_cnt == (r_full ? 4'd8 : 4'd2));

  // First slot to refill for the accepted request
  always_comb begin
    w_row0 = 2'd0;
    w_col0 = 2'd0;
    if (!w_full_req) begin
      case (direction)
        DIR_RIGHT: w_col0 = 2'd2;
        DIR_DOWN:  w_row0 = 2'd2;
        default: ;
      endcase
    end
  end

  // Raster order for full loads; walk the refilled column or row otherwise
  always_comb begin
    w_next_row = r_row;
    w_next_col = r_col;
    if (r_full) begin
      if (r_col == 2'd2) begin
        w_next_col = 2'd0;
        w_next_row = r_row + 2'd1;
      end else begin
        w_next_col = r_col + 2'd1;
      end
    end else if (r_dir == DIR_DOWN) begin
      w_next_col = r_col + 2'd1;
    end else begin
      w_next_row = r_row + 2'd1;
    end
  end

`ifdef WINDOW_LOADER_TIMEOUT_EN
  logic [4:0] r_tmo;
  logic       r_err;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_width    <= '0;
      r_dir      <= DIR_NONE;
      r_full     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_cnt      <= '0;
      r_mem_ren  <= 1'b0;
      r_mem_addr <= '0;
      r_valid    <= 1'b0;
`ifdef WINDOW_LOADER_TIMEOUT_EN
      r_tmo      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_mem_ren <= 1'b0;
      r_valid   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_base     <= base_addr;
            r_width    <= width;
            r_dir      <= direction;
            r_full     <= w_full_req;
            r_row      <= w_row0;
            r_col      <= w_col0;
            r_cnt      <= '0;
            r_mem_ren  <= 1'b1;
            r_mem_addr <= pix_addr(base_addr, width, w_row0, w_col0);
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef WINDOW_LOADER_TIMEOUT_EN
          r_tmo   <= '0;
`endif
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (w_last) begin
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_row      <= w_next_row;
              r_col      <= w_next_col;
              r_cnt      <= r_cnt + 4'd1;
              r_mem_ren  <= 1'b1;
              r_mem_addr <= pix_addr(r_base, r_width, w_next_row, w_next_col);
              r_state    <= ST_ISSUE;
            end
          end
`ifdef WINDOW_LOADER_TIMEOUT_EN
          // 16th cycle in WAIT with no data: abandon the fetch
          else if (r_tmo == 5'd15) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 5'd1;
          end
`endif
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  window_shift_reg #(.PIXEL_W(PIXEL_W)) u_win (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_shift_en (w_shift_en),
    .i_dir      (direction),
    .i_wr_en    (w_wr_en),
    .i_wr_row   (r_row),
    .i_wr_col   (r_col),
    .i_wr_data  (mem_rdata),
    .o_window   (window)
  );

  assign mem_ren      = r_mem_ren;
  assign mem_addr     = r_mem_addr;
  assign window_valid = r_valid;
  assign busy         = (r_state != ST_IDLE);
`ifdef WINDOW_LOADER_TIMEOUT_EN
  assign mem_err      = r_err;
`else
  assign mem_err      = 1'b0;
`endif

endmodule

// File: tb/tb_window_loader.sv
// tb_window_loader: directed stimulus with a scoreboard. Requests push the
// expected read addresses and the expected window (with its completion cycle)
// into queues; a negedge monitor pops and compares on mem_ren / window_valid.
// Memory model: latency 1, returns data = addr[7:0].
module tb_window_loader;
  import sobel_pkg::*;

  localparam int AW = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [11:0]   width = '0;
  logic [AW-1:0] base_addr = '0;
  logic [1:0]    direction = '0;
  logic          load_initial = 1'b0;
  logic          start_fetch = 1'b0;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [9*PW-1:0] window;
  logic          window_valid;
  logic          busy;
  logic          mem_err;

  window_loader #(.ADDR_W(AW), .PIXEL_W(PW)) dut (
    .clk(clk), .n_reset(n_reset), .width(width), .base_addr(base_addr),
    .direction(direction), .load_initial(load_initial), .start_fetch(start_fetch),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .window(window), .window_valid(window_valid),
    .busy(busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cnt = 0;   // posedges seen so far
  always @(posedge clk) cnt <= cnt + 1;

  int tests = 0;
  int fails = 0;

  typedef int arr9_t [9];
  typedef struct { logic [9*PW-1:0] win; int edge_n; } win_exp_t;

  logic [AW-1:0] exp_addr_q [$];
  win_exp_t      exp_win_q  [$];
  logic          mute = 1'b0;

  // Latency-1 memory; mute suppresses responses to provoke a timeout
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= mem_ren && !mute;
      mem_rdata  <= mem_addr;
    end
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] mk(input arr9_t v);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = v[i][7:0];
    return w;
  endfunction

  task automatic push_addrs(input arr9_t a, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(a[i][7:0]);
  endtask

  // Called at a negedge; request is sampled at the following posedge.
  task automatic req(input logic li, input logic sf, input logic [1:0] dir,
                     input logic [7:0] base, input logic [11:0] w, input int n,
                     input logic [71:0] win, input logic push_win);
    win_exp_t e;
    load_initial = li;
    start_fetch  = sf;
    direction    = dir;
    base_addr    = base;
    width        = w;
    if (push_win) begin
      e.win    = win;
      e.edge_n = cnt + 1 + 2 * n;
      exp_win_q.push_back(e);
    end
    @(posedge clk);
    #1;
    load_initial = 1'b0;
    start_fetch  = 1'b0;
  endtask

  // Returns at the first negedge with busy low
  task automatic wait_idle(input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s: still busy after 300 cycles", name);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (n_reset) begin
      if (mem_ren) begin
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL read_addr: unexpected read at %0d, none expected", mem_addr);
        end else begin
          chk("read_addr", 72'(mem_addr), 72'(exp_addr_q.pop_front()));
        end
      end
      if (window_valid) begin
        if (exp_win_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL window_valid: unexpected strobe at cycle %0d, none expected", cnt);
        end else begin
          win_exp_t e;
          e = exp_win_q.pop_front();
          chk("window", window, e.win);
          chk("valid_cycle", 72'(cnt), 72'(e.edge_n));
        end
      end
    end
  end

  initial begin
    arr9_t w1, w2, w3, w4, w5, ww, w0;
    w1 = '{100,101,102,105,106,107,110,111,112};
    w2 = '{101,102,103,106,107,108,111,112,113};
    w3 = '{106,107,108,111,112,113,116,117,118};
    w4 = '{105,106,107,110,111,112,115,116,117};
    w5 = '{106,107,108,111,112,113,116,117,118};
    ww = '{250,251,252,255,0,1,4,5,6};
    w0 = '{0,1,2,3,4,5,6,7,8};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ren",   72'(mem_ren), 72'(0));
    chk("rst_addr",  72'(mem_addr), 72'(0));
    chk("rst_valid", 72'(window_valid), 72'(0));
    chk("rst_busy",  72'(busy), 72'(0));
    chk("rst_err",   72'(mem_err), 72'(0));
    chk("rst_win",   window, 72'(0));
    n_reset = 1'b1;
    @(negedge clk);

    // Full load, base 100, width 5
    push_addrs(w1, 9);
    req(1'b1, 1'b0, DIR_NONE, 8'd100, 12'd5, 9, mk(w1), 1'b1);
    wait_idle("full_load");

    // Move right (back-to-back with previous valid)
    push_addrs('{103,108,113,0,0,0,0,0,0}, 3);
    req(1'b0, 1'b1, DIR_RIGHT, 8'd101, 12'd5, 3, mk(w2), 1'b1);
    wait_idle("move_right");

    // Row advance
    push_addrs('{116,117,118,0,0,0,0,0,0}, 3);
    req(1'b0, 1'b1, DIR_DOWN, 8'd106, 12'd5, 3, mk(w3), 1'b1);
    wait_idle("move_down");

    // Move left
    push_addrs('{105,110,115,0,0,0,0,0,0}, 3);
    req(1'b0, 1'b1, DIR_LEFT, 8'd105, 12'd5, 3, mk(w4), 1'b1);
    wait_idle("move_left");

    // Requests while busy are dropped
    push_addrs('{108,113,118,0,0,0,0,0,0}, 3);
    req(1'b0, 1'b1, DIR_RIGHT, 8'd106, 12'd5, 3, mk(w5), 1'b1);
    @(negedge clk);
    @(negedge clk);
    start_fetch = 1'b1; base_addr = 8'd0; direction = DIR_DOWN;
    @(negedge clk);
    start_fetch = 1'b0; load_initial = 1'b1;
    @(negedge clk);
    load_initial = 1'b0;
    wait_idle("busy_drop");

    // Both requests together -> full load
    push_addrs(w1, 9);
    req(1'b1, 1'b1, DIR_RIGHT, 8'd100, 12'd5, 9, mk(w1), 1'b1);
    wait_idle("both_req");

    // Address wrap
    push_addrs(ww, 9);
    req(1'b1, 1'b0, DIR_NONE, 8'd250, 12'd5, 9, mk(ww), 1'b1);
    wait_idle("wrap");

    // Reset while waiting on the first read
    push_addrs('{100,0,0,0,0,0,0,0,0}, 1);
    req(1'b1, 1'b0, DIR_NONE, 8'd100, 12'd5, 9, '0, 1'b0);
    @(negedge clk);   // ISSUE
    @(negedge clk);   // WAIT
    n_reset = 1'b0;
    #1;
    chk("mid_rst_ren",   72'(mem_ren), 72'(0));
    chk("mid_rst_addr",  72'(mem_addr), 72'(0));
    chk("mid_rst_valid", 72'(window_valid), 72'(0));
    chk("mid_rst_busy",  72'(busy), 72'(0));
    chk("mid_rst_err",   72'(mem_err), 72'(0));
    chk("mid_rst_win",   window, 72'(0));
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 72'(busy), 72'(0));

    // start_fetch with direction 00 -> full load
    push_addrs(w0, 9);
    req(1'b0, 1'b1, DIR_NONE, 8'd0, 12'd3, 9, mk(w0), 1'b1);
    wait_idle("dir_none");

`ifdef WINDOW_LOADER_TIMEOUT_EN
    mute = 1'b1;
    push_addrs('{2,0,0,0,0,0,0,0,0}, 1);
    req(1'b0, 1'b1, DIR_RIGHT, 8'd0, 12'd3, 3, '0, 1'b0);
    repeat (25) @(negedge clk);
    chk("tmo_err",  72'(mem_err), 72'(1));
    chk("tmo_busy", 72'(busy), 72'(0));
    mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("tmo_sticky", 72'(mem_err), 72'(1));
`else
    chk("err_tied", 72'(mem_err), 72'(0));
`endif

    repeat (3) @(negedge clk);
    chk("reads_left", 72'(exp_addr_q.size()), 72'(0));
    chk("wins_left",  72'(exp_win_q.size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
